// File: rtl/rc4_key_search_scheduler.sv
// rc4_key_search_scheduler: hands candidate keys to idle RC4 cores, stops on first match or after KEY_LAST.
// Define RESULT_LED_EN to add the 10-bit LED status port.
module rc4_key_search_scheduler #(
    parameter int               NUM_CORES = 4,
    parameter int               KEY_W     = 24,
    parameter logic [KEY_W-1:0] KEY_LAST  = {KEY_W{1'b1}}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_CORES-1:0]       core_done,
    input  logic [NUM_CORES-1:0]       core_match,
    output logic [NUM_CORES-1:0]       core_start,
    output logic [NUM_CORES*KEY_W-1:0] core_key,
    output logic                       core_abort,
    output logic                       busy,
    output logic                       found,
    output logic                       exhausted,
    output logic [KEY_W-1:0]           found_key,
    output logic [KEY_W-1:0]           keys_tried
`ifdef RESULT_LED_EN
    ,
    output logic [9:0]                 LED
`endif
);
    localparam int CW = $clog2(NUM_CORES + 1);
    localparam int TW = KEY_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, FOUND, FAIL} state_t;
    state_t state, state_nx;

    // one extra bit so KEY_LAST = all-ones still terminates
    logic [TW-1:0]        next_key, tried_sum;
    logic [NUM_CORES-1:0] busy_q, done_v, match_v, dispatch_oh;
    logic [KEY_W-1:0]     match_key;
    logic [CW-1:0]        n_done;
    logic                 any_match, keys_left, can_dispatch;

    always_comb begin
        done_v      = core_done & busy_q;
        match_v     = done_v & core_match;
        any_match   = |match_v;
        keys_left   = next_key <= {1'b0, KEY_LAST};
        dispatch_oh = '0;
        match_key   = '0;
        n_done      = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                dispatch_oh    = '0;
                dispatch_oh[i] = 1'b1;
            end
            if (match_v[i]) match_key = core_key[i*KEY_W +: KEY_W];
            n_done = n_done + CW'(done_v[i]);
        end
        can_dispatch = state == RUN && !any_match && keys_left && !(&busy_q);
        tried_sum    = {1'b0, keys_tried} + TW'(n_done);
        state_nx     = state;
        if (state == RUN)
            state_nx = any_match ? FOUND :
                       (!keys_left && (busy_q & ~done_v) == '0) ? FAIL : RUN;
        else if (start)
            state_nx = RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            next_key   <= '0;
            busy_q     <= '0;
            core_start <= '0;
            core_key   <= '0;
            core_abort <= 1'b0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            found_key  <= '0;
            keys_tried <= '0;
        end else begin
            state      <= state_nx;
            core_start <= '0;
            core_abort <= 1'b0;
            if (state != RUN && start) begin
                found      <= 1'b0;
                exhausted  <= 1'b0;
                keys_tried <= '0;
                next_key   <= '0;
            end
            if (state == RUN) begin
                keys_tried <= tried_sum[KEY_W] ? '1 : tried_sum[KEY_W-1:0];
                busy_q     <= any_match ? '0 : (busy_q & ~done_v) | (can_dispatch ? dispatch_oh : '0);
                if (any_match) begin
                    found      <= 1'b1;
                    found_key  <= match_key;
                    core_abort <= 1'b1;
                end
                if (state_nx == FAIL) exhausted <= 1'b1;
                if (can_dispatch) begin
                    core_start <= dispatch_oh;
                    next_key   <= next_key + TW'(1);
                    for (int i = 0; i < NUM_CORES; i++)
                        if (dispatch_oh[i]) core_key[i*KEY_W +: KEY_W] <= next_key[KEY_W-1:0];
                end
            end
        end
    end

    assign busy = state == RUN;

`ifdef RESULT_LED_EN
    always_comb
        LED = state == FOUND ? 10'b11_1100_0000 :
              state == FAIL  ? 10'b00_0011_1111 :
              state == RUN   ? {busy_q, {(10 - NUM_CORES){1'b0}}} : 10'd0;
`endif
endmodule

// File: tb/tb_rc4_key_search_scheduler.sv
// tb_rc4_key_search_scheduler: table of core-model searches plus directed multi-cycle sequences.
module tb_rc4_key_search_scheduler;
    localparam int               NC = 4;
    localparam int               KW = 24;
    localparam logic [KW-1:0]    KL = 24'h00000F;

    logic             clk = 1'b0;
    logic             reset, start;
    logic [NC-1:0]    core_done, core_match, core_start;
    logic [NC*KW-1:0] core_key;
    logic             core_abort, busy, found, exhausted;
    logic [KW-1:0]    found_key, keys_tried;

    int vectors = 0, miscompares = 0;

    rc4_key_search_scheduler #(.NUM_CORES(NC), .KEY_W(KW), .KEY_LAST(KL)) dut (
        .clk(clk), .reset(reset), .start(start), .core_done(core_done), .core_match(core_match),
        .core_start(core_start), .core_key(core_key), .core_abort(core_abort), .busy(busy),
        .found(found), .exhausted(exhausted), .found_key(found_key), .keys_tried(keys_tried)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            has_match;
        logic [KW-1:0] mkey;
        int            lat;
        bit            exp_found;
        logic [KW-1:0] exp_key;
        bit            exp_exh;
        int            exp_tried;
        int            exp_starts;
        int            exp_aborts;
    } case_t;

    case_t cases[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // behavioural cores: each finishes lat cycles after its start pulse
    task automatic run_case(input case_t c, input int idx);
        bit            active[NC];
        int            cnt[NC];
        logic [KW-1:0] ck[NC];
        bit            seen[16];
        bit            ended = 0;
        int            starts = 0, aborts = 0, bad = 0, extra = -1, cyc = 0;
        logic [KW-1:0] k;
        for (int n = 0; n < NC; n++) active[n] = 0;
        for (int n = 0; n < 16; n++) seen[n] = 0;
        pulse_start();
        while (extra != 0 && cyc < 3000) begin
            bit fresh[NC];
            if (!ended && (found || exhausted)) begin
                ended = 1;
                extra = 6;
            end
            if (core_abort) begin
                aborts++;
                for (int n = 0; n < NC; n++) active[n] = 0;
            end
            if ($countones(core_start) > 1) bad++;
            for (int n = 0; n < NC; n++) begin
                fresh[n] = 0;
                if (core_start[n]) begin
                    starts++;
                    k = core_key[n*KW +: KW];
                    if (active[n] || ended || k > KL) bad++;
                    else if (seen[k[3:0]]) bad++;
                    else seen[k[3:0]] = 1;
                    active[n] = 1;
                    fresh[n]  = 1;
                    cnt[n]    = c.lat;
                    ck[n]     = k;
                end
            end
            core_done  = '0;
            core_match = '0;
            for (int n = 0; n < NC; n++)
                if (active[n] && !fresh[n]) begin
                    cnt[n]--;
                    if (cnt[n] == 0) begin
                        core_done[n]  = 1'b1;
                        core_match[n] = c.has_match && ck[n] == c.mkey;
                        active[n]     = 0;
                    end
                end
            if (extra > 0) extra--;
            cyc++;
            @(negedge clk);
        end
        core_done  = '0;
        core_match = '0;
        check($sformatf("c%0d_terminated", idx), 64'(ended), 64'd1);
        check($sformatf("c%0d_found", idx), 64'(found), 64'(c.exp_found));
        if (c.exp_found) check($sformatf("c%0d_found_key", idx), 64'(found_key), 64'(c.exp_key));
        check($sformatf("c%0d_exhausted", idx), 64'(exhausted), 64'(c.exp_exh));
        check($sformatf("c%0d_keys_tried", idx), 64'(keys_tried), 64'(c.exp_tried));
        check($sformatf("c%0d_starts", idx), 64'(starts), 64'(c.exp_starts));
        check($sformatf("c%0d_aborts", idx), 64'(aborts), 64'(c.exp_aborts));
        check($sformatf("c%0d_busy", idx), 64'(busy), 64'd0);
        check($sformatf("c%0d_protocol_errors", idx), 64'(bad), 64'd0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctrl"}, 64'({core_start, core_abort, busy, found, exhausted}), 64'd0);
        check({name, "_keys"}, 64'({found_key, keys_tried}), 64'd0);
        check({name, "_core_key"}, 64'(|core_key), 64'd0);
    endtask

    initial begin
        //                match mkey  lat fnd key    exh tried starts aborts
        cases[0] = '{1'b1, 24'd7,  40, 1'b1, 24'd7,  1'b0, 8,  10, 1};
        cases[1] = '{1'b0, 24'd0,  40, 1'b0, 24'd0,  1'b1, 16, 16, 0};
        cases[2] = '{1'b1, 24'd15, 5,  1'b1, 24'd15, 1'b0, 16, 16, 1};
        cases[3] = '{1'b1, 24'd0,  40, 1'b1, 24'd0,  1'b0, 1,  4,  1};
        cases[4] = '{1'b1, 24'd3,  3,  1'b1, 24'd3,  1'b0, 4,  6,  1};

        reset = 1'b1; start = 1'b0; core_done = '0; core_match = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_case(cases[i], i);

        // simultaneous matches on cores 1 and 3: lowest index wins
        pulse_start();
        repeat (4) @(negedge clk);
        check("sim_start3", 64'(core_start), 64'b1000);
        check("sim_key1", 64'(core_key[1*KW +: KW]), 64'd1);
        core_done = 4'b1010; core_match = 4'b1010;
        @(negedge clk);
        core_done = '0; core_match = '0;
        check("sim_found", 64'({found, core_abort, core_start}), 64'b1_1_0000);
        check("sim_found_key", 64'(found_key), 64'd1);
        check("sim_tried", 64'(keys_tried), 64'd2);
        @(negedge clk);
        check("sim_abort_once", 64'({core_abort, busy}), 64'd0);

        // cores 0 and 2 free together; non-busy done/match ignored
        pulse_start();
        repeat (4) @(negedge clk);
        core_done = 4'b0101;
        @(negedge clk);
        check("free_no_start", 64'(core_start), 64'd0);
        check("free_tried", 64'(keys_tried), 64'd2);
        core_done = 4'b0100; core_match = 4'b0100;
        @(negedge clk);
        core_done = '0; core_match = '0;
        check("free_core0", 64'(core_start), 64'b0001);
        check("free_key0", 64'(core_key[0*KW +: KW]), 64'd4);
        check("idle_done_ignored", 64'({found, keys_tried}), 64'd2);
        @(negedge clk);
        check("free_core2", 64'(core_start), 64'b0100);
        check("free_key2", 64'(core_key[2*KW +: KW]), 64'd5);
        @(negedge clk);
        check("free_quiet", 64'(core_start), 64'd0);

        // start during RUN is ignored
        pulse_start();
        check("busy_start_ignored", 64'({busy, core_start, keys_tried}), {39'd0, 1'b1, 4'd0, 24'd2});

        // async reset mid-run with three cores busy
        pulse_start();
        #2 reset = 1'b1;
        #1 check_zero("areset1");
        @(negedge clk);
        reset = 1'b0;
        pulse_start();
        repeat (3) @(negedge clk);
        check("pre_reset_start2", 64'(core_start), 64'b0100);
        #2 reset = 1'b1;
        #1 check_zero("areset2");
        @(negedge clk);
        reset = 1'b0;
        pulse_start();
        check("restart_latency", 64'({busy, core_start}), 64'b1_0000);
        @(negedge clk);
        check("restart_core0", 64'(core_start), 64'b0001);
        check("restart_key0", 64'(core_key[0*KW +: KW]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
